// File: rtl/fsk_pkg.sv
// Shared types and default constants for the FSK transmit frame controller.
// No logic, no latency.
// No flow control of its own.
package fsk_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SYNC     = 3'd2,
        LENGTH   = 3'd3,
        PAYLOAD  = 3'd4,
        TAIL     = 3'd5
    } fsk_state_t;

    localparam int unsigned BIT_CYCLES_100K   = 500;
    localparam int unsigned PREAMBLE_BITS_DEF = 16;
    localparam int unsigned TAIL_BITS_DEF     = 4;
    localparam logic [7:0]  SYNC_WORD_DEF     = 8'hD3;

    // Sent in place of a payload byte that had not arrived by its boundary.
    localparam logic [7:0]  UNDERRUN_BYTE     = 8'h00;

endpackage

// File: rtl/fsk_bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 and flags the last count as tick.
// tick is combinational from the count register; count wraps on the tick edge.
// No backpressure; clr dominates en.
module fsk_bit_timer #(
    parameter int unsigned BIT_CYCLES = 500
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned   CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fsk_frame_ctrl.sv
// FSK transmit sequencer: preamble, sync, length, payload, tail, one bit per BIT_CYCLES.
// First bit appears the edge start is sampled; each later bit loads on a timer tick.
// One-byte prefetch buffer; a byte missing at its boundary is replaced by 00 and flagged.
module fsk_frame_ctrl
    import fsk_pkg::*;
#(
    parameter int unsigned BIT_CYCLES    = BIT_CYCLES_100K,
    parameter int unsigned PREAMBLE_BITS = PREAMBLE_BITS_DEF,
    parameter logic [7:0]  SYNC_WORD     = SYNC_WORD_DEF,
    parameter int unsigned TAIL_BITS     = TAIL_BITS_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [7:0] len,
    input  logic       abort,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       fsk_bit,
    output logic       fsk_en,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_BITS - 1);
    localparam logic [15:0] TAIL_LAST = 16'(TAIL_BITS - 1);

    fsk_state_t state;
    logic [15:0] phase_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  len_q;
    logic [7:0]  bytes_acc;
    logic [7:0]  bytes_sent;
    logic [7:0]  buf_dat;
    logic        buf_full;

    logic        tick;
    logic        timer_clr;
    logic        timer_en;
    logic        in_byte_state;
    logic        payload_left;
    logic        boundary;
    logic        xfer;
    logic [7:0]  next_byte;
    logic [8:0]  acc_sum;
    logic [7:0]  acc_next;

    assign timer_clr = (state == IDLE) || abort;
    assign timer_en  = (state != IDLE);

    fsk_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (timer_clr),
        .en        (timer_en),
        .tick      (tick)
    );

    assign in_byte_state = (state == SYNC) || (state == LENGTH) || (state == PAYLOAD);
    assign tx_ready      = !buf_full && in_byte_state && (bytes_acc < len_q);
    assign xfer          = tx_valid && tx_ready;

    assign payload_left  = (bytes_sent != len_q);
    assign boundary      = tick && ((state == LENGTH) || (state == PAYLOAD))
                           && (bit_idx == 3'd7) && payload_left;
    assign next_byte     = buf_full ? buf_dat : UNDERRUN_BYTE;

    // A substituted byte consumes a slot, so the count saturates at len.
    assign acc_sum  = {1'b0, bytes_acc} + 9'(xfer) + 9'(boundary && !buf_full);
    assign acc_next = (acc_sum > {1'b0, len_q}) ? len_q : acc_sum[7:0];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            len_q      <= '0;
            bytes_acc  <= '0;
            bytes_sent <= '0;
            buf_dat    <= '0;
            buf_full   <= 1'b0;
            fsk_bit    <= 1'b0;
            fsk_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state      <= PREAMBLE;
                    fsk_en     <= 1'b1;
                    busy       <= 1'b1;
                    fsk_bit    <= 1'b1;
                    phase_cnt  <= '0;
                    len_q      <= len;
                    bytes_acc  <= '0;
                    bytes_sent <= '0;
                    buf_full   <= 1'b0;
                end
            end else if (abort) begin
                state    <= IDLE;
                fsk_en   <= 1'b0;
                busy     <= 1'b0;
                fsk_bit  <= 1'b0;
                buf_full <= 1'b0;
            end else begin
                bytes_acc <= acc_next;
                if (xfer) begin
                    buf_dat  <= tx_data;
                    buf_full <= 1'b1;
                end
                if (tick) begin
                    case (state)
                        PREAMBLE: begin
                            if (phase_cnt == PRE_LAST) begin
                                state   <= SYNC;
                                fsk_bit <= SYNC_WORD[7];
                                shreg   <= {SYNC_WORD[6:0], 1'b0};
                                bit_idx <= '0;
                            end else begin
                                phase_cnt <= phase_cnt + 16'd1;
                                fsk_bit   <= ~fsk_bit;
                            end
                        end
                        SYNC, LENGTH, PAYLOAD: begin
                            if (bit_idx != 3'd7) begin
                                fsk_bit <= shreg[7];
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_idx <= bit_idx + 3'd1;
                            end else if (state == SYNC) begin
                                state   <= LENGTH;
                                fsk_bit <= len_q[7];
                                shreg   <= {len_q[6:0], 1'b0};
                                bit_idx <= '0;
                            end else if (payload_left) begin
                                state      <= PAYLOAD;
                                fsk_bit    <= next_byte[7];
                                shreg      <= {next_byte[6:0], 1'b0};
                                bit_idx    <= '0;
                                bytes_sent <= bytes_sent + 8'd1;
                                if (buf_full) begin
                                    buf_full <= 1'b0;
                                end else begin
                                    underrun <= 1'b1;
                                end
                            end else begin
                                state     <= TAIL;
                                fsk_bit   <= 1'b0;
                                phase_cnt <= '0;
                            end
                        end
                        TAIL: begin
                            if (phase_cnt == TAIL_LAST) begin
                                state    <= IDLE;
                                fsk_en   <= 1'b0;
                                busy     <= 1'b0;
                                fsk_bit  <= 1'b0;
                                done     <= 1'b1;
                                buf_full <= 1'b0;
                            end else begin
                                phase_cnt <= phase_cnt + 16'd1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_fsk_frame_ctrl.sv
// Directed bench for fsk_frame_ctrl: a 4-cycle-per-bit instance driven from a vector
// table, plus a default 500-cycle instance for start filtering and back-to-back frames.
module tb_fsk_frame_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start4 = 1'b0;
    logic       start5 = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] len = 8'h00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    logic tx_ready4, fsk_bit4, fsk_en4, busy4, done4, underrun4;
    logic tx_ready5, fsk_bit5, fsk_en5, busy5, done5, underrun5;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [7:0] SYNC_REF = 8'hD3;

    always #5 sys_clk = ~sys_clk;

    fsk_frame_ctrl #(.BIT_CYCLES(4)) dut4 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start4), .len(len),
        .abort(abort), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready4),
        .fsk_bit(fsk_bit4), .fsk_en(fsk_en4), .busy(busy4), .done(done4),
        .underrun(underrun4)
    );

    fsk_frame_ctrl dut500 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start5), .len(len),
        .abort(abort), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready5),
        .fsk_bit(fsk_bit5), .fsk_en(fsk_en5), .busy(busy5), .done(done5),
        .underrun(underrun5)
    );

    typedef struct {
        int         len;
        logic [7:0] o0, o1, o2;     // bytes offered in order
        int         late_idx;       // byte index withheld until late_cyc (-1: none)
        int         late_cyc;
        int         abort_cyc;      // frame cycle with abort high (-1: none)
        logic [7:0] e0, e1, e2;     // payload bytes expected on the line
        int         exp_busy;
        int         exp_done;
        int         exp_unr;
        int         exp_taken;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(int l, logic [7:0] o0, logic [7:0] o1, logic [7:0] o2,
                                int li, int lc, int ac, logic [7:0] e0, logic [7:0] e1,
                                logic [7:0] e2, int eb, int ed, int eu, int et);
        vec_t v;
        v.len = l; v.o0 = o0; v.o1 = o1; v.o2 = o2;
        v.late_idx = li; v.late_cyc = lc; v.abort_cyc = ac;
        v.e0 = e0; v.e1 = e1; v.e2 = e2;
        v.exp_busy = eb; v.exp_done = ed; v.exp_unr = eu; v.exp_taken = et;
        return v;
    endfunction

    function automatic logic [7:0] offer(input vec_t v, input int i);
        case (i)
            0:       return v.o0;
            1:       return v.o1;
            2:       return v.o2;
            default: return 8'h00;
        endcase
    endfunction

    // Expected line bit k of a frame built from v.
    function automatic logic exp_bit(input vec_t v, input int k);
        logic [7:0] b;
        int j;
        if (k < 16) return (k % 2 == 0);
        j = k - 16;
        if (j < 8) begin b = SYNC_REF; return b[7 - j]; end
        j = j - 8;
        if (j < 8) begin b = 8'(v.len); return b[7 - j]; end
        j = j - 8;
        if (j < 8 * v.len) begin
            case (j / 8)
                0:       b = v.e0;
                1:       b = v.e1;
                default: b = v.e2;
            endcase
            return b[7 - (j % 8)];
        end
        return 1'b0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int idx, input int c);
        tx_valid = (idx < 3) && !(v.late_idx >= 0 && idx >= v.late_idx && c < v.late_cyc);
        tx_data  = offer(v, idx);
        abort    = (c == v.abort_cyc);
    endtask

    // Starts a frame on dut4 from just after a rising edge and follows it until busy drops.
    task automatic run_vec(input vec_t v, input int r);
        int c = 0, idx = 0, busy_n = 0, unr_n = 0, rdy_n = 0, mis = 0, en_mis = 0;
        logic fin = 1'b0, xfer, done_s = 1'b0, en_s = 1'b1, bit_s = 1'b1;
        len = 8'(v.len);
        start4 = 1'b1;
        drive(v, idx, -1);
        @(posedge sys_clk); #1;
        start4 = 1'b0;
        drive(v, idx, c);
        while (!fin && c < 400) begin
            @(negedge sys_clk);
            if (!busy4) begin
                fin = 1'b1;
                done_s = done4; en_s = fsk_en4; bit_s = fsk_bit4;
            end else begin
                busy_n++;
                if (!fsk_en4) en_mis++;
                if (fsk_bit4 !== exp_bit(v, c / 4)) mis++;
                if (underrun4) unr_n++;
                if (tx_ready4) rdy_n++;
                xfer = tx_valid && tx_ready4;
                @(posedge sys_clk); #1;
                if (xfer) idx++;
                c++;
                drive(v, idx, c);
            end
        end
        tx_valid = 1'b0;
        abort = 1'b0;
        check($sformatf("row%0d_ended", r), int'(fin), 1);
        check($sformatf("row%0d_busy_cycles", r), busy_n, v.exp_busy);
        check($sformatf("row%0d_bit_errors", r), mis, 0);
        check($sformatf("row%0d_en_gaps", r), en_mis, 0);
        check($sformatf("row%0d_done", r), int'(done_s), v.exp_done);
        check($sformatf("row%0d_end_en_bit", r), int'({en_s, bit_s}), 0);
        check($sformatf("row%0d_underruns", r), unr_n, v.exp_unr);
        check($sformatf("row%0d_bytes_taken", r), idx, v.exp_taken);
        if (v.len == 0) check($sformatf("row%0d_ready_cycles", r), rdy_n, 0);
        @(posedge sys_clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_n, dn_n, rdy_n, unr_n, en_mis, hold;
        logic done_end, busy_end, fin;

        //           len o0     o1     o2     li  lc      ac   e0     e1     e2     busy done unr taken
        vecs[0] = mk(2, 8'hA5, 8'h3C, 8'h00, -1, 0,      -1, 8'hA5, 8'h3C, 8'h00, 208, 1, 0, 2);
        vecs[1] = mk(0, 8'h77, 8'h00, 8'h00, -1, 0,      -1, 8'h00, 8'h00, 8'h00, 144, 1, 0, 0);
        vecs[2] = mk(3, 8'h11, 8'hC7, 8'h5E,  1, 170,    -1, 8'h11, 8'h00, 8'hC7, 240, 1, 1, 2);
        vecs[3] = mk(1, 8'h81, 8'h00, 8'h00, -1, 0,      -1, 8'h81, 8'h00, 8'h00, 176, 1, 0, 1);
        vecs[4] = mk(1, 8'h5A, 8'h00, 8'h00,  0, 100000, -1, 8'h00, 8'h00, 8'h00, 176, 1, 1, 0);
        vecs[5] = mk(2, 8'hA5, 8'h3C, 8'h00, -1, 0,      81, 8'hA5, 8'h3C, 8'h00, 82,  0, 0, 1);
        vecs[6] = mk(1, 8'hE7, 8'h00, 8'h00, -1, 0,      -1, 8'hE7, 8'h00, 8'h00, 176, 1, 0, 1);

        #2;
        check("reset_outputs", int'({tx_ready4, fsk_bit4, fsk_en4, busy4, done4, underrun4,
                                     tx_ready5, fsk_bit5, fsk_en5, busy5, done5, underrun5}), 0);
        @(posedge sys_clk); @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Abort row is followed straight away by a fresh frame.
        for (int r = 0; r < 7; r++) run_vec(vecs[r], r);

        // Asynchronous reset in the middle of the payload.
        len = 8'd2;
        start4 = 1'b1;
        @(posedge sys_clk); #1;
        start4 = 1'b0;
        repeat (140) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_pre_busy", int'(busy4), 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("rst_async_outputs", int'({tx_ready4, fsk_bit4, fsk_en4, busy4, done4, underrun4}), 0);
        @(posedge sys_clk); @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        run_vec(vecs[1], 7);

        // Default bit period: mid-frame start ignored, start in the done cycle accepted.
        busy_n = 0; dn_n = 0; rdy_n = 0; unr_n = 0; en_mis = 0;
        done_end = 1'b0; busy_end = 1'b1;
        len = 8'd0;
        start5 = 1'b1;
        @(posedge sys_clk); #1;
        for (int c = 0; c <= 18000; c++) begin
            start5 = (c == 1000) || (c == 18000);
            len    = (c == 1000) ? 8'd5 : 8'd0;
            @(negedge sys_clk);
            if (done5) dn_n++;
            if (tx_ready5) rdy_n++;
            if (underrun5) unr_n++;
            if (c < 18000) begin
                if (busy5) busy_n++;
                if (fsk_en5 != busy5) en_mis++;
                @(posedge sys_clk); #1;
            end else begin
                done_end = done5;
                busy_end = busy5;
            end
        end
        @(posedge sys_clk); #1;
        start5 = 1'b0;
        check("b500_busy_cycles", busy_n, 18000);
        check("b500_done_pulses", dn_n, 1);
        check("b500_done_at_end", int'({done_end, busy_end}), 2);
        check("b500_ready_cycles", rdy_n, 0);
        check("b500_underruns", unr_n, 0);
        check("b500_en_gaps", en_mis, 0);

        hold = 0;
        fin = 1'b0;
        for (int k = 0; k < 600 && !fin; k++) begin
            @(negedge sys_clk);
            if (busy5 && fsk_bit5 && !done5) hold++;
            else fin = 1'b1;
            if (!fin) begin
                @(posedge sys_clk); #1;
            end
        end
        check("b500_first_bit_hold", hold, 500);
        check("b500_second_bit", int'({busy5, fsk_bit5}), 2);

        @(posedge sys_clk); #1;
        abort = 1'b1;
        @(posedge sys_clk); #1;
        abort = 1'b0;
        @(negedge sys_clk);
        check("b500_abort_idle", int'({busy5, fsk_en5, fsk_bit5, done5}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
